// File: rtl/pll_lock_rst_seq.sv
// PLL reset sequencer: pulses PLL RST, qualifies lock, releases fabric reset.
// Optional retry limit / FAIL state: define PLL_LOCK_RST_SEQ_RETRY_LIMIT_EN.
`timescale 1ns/1ps
module pll_lock_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int MAX_RETRY     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_out,
    output logic       ready,
    output logic [7:0] loss_cnt,
    output logic [2:0] state_dbg
);

    localparam int MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ?
                           LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAXC  = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
    localparam int CW    = $clog2(MAXC) + 1;
    localparam int GW    = $clog2(GLITCH_CYCLES) + 1;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3
`ifdef PLL_LOCK_RST_SEQ_RETRY_LIMIT_EN
        ,
        FAIL      = 3'd4
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] glitch, glitch_n;
    logic [2:0]    retry, retry_n;
    logic [7:0]    loss_n;
    logic          sync1, lk;
    logic          pll_rst_n;

    // pll_locked comes from the PLL's own domain; never use it raw
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        glitch_n = '0;
        retry_n  = retry;
        loss_n   = loss_cnt;
        unique case (state)
            PLL_RESET: begin
                if (cnt == CW'(RST_CYCLES - 1))
                    state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_n = STABLE;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_n = (retry == 3'd7) ? retry : retry + 3'd1;
`ifdef PLL_LOCK_RST_SEQ_RETRY_LIMIT_EN
                    if (retry == 3'(MAX_RETRY))
                        state_n = FAIL;
                    else
                        state_n = PLL_RESET;
`else
                    state_n = PLL_RESET;
`endif
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_n = WAIT_LOCK;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_n = RUN;
                    retry_n = 3'd0;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!lk) begin
                    if (glitch == GW'(GLITCH_CYCLES - 1)) begin
                        state_n = PLL_RESET;
                        loss_n  = (loss_cnt == 8'hff) ?
                                  loss_cnt : loss_cnt + 8'd1;
                    end else begin
                        glitch_n = glitch + GW'(1);
                    end
                end
            end
`ifdef PLL_LOCK_RST_SEQ_RETRY_LIMIT_EN
            FAIL: begin
                cnt_n = '0;
            end
`endif
            default: begin
                state_n = PLL_RESET;
            end
        endcase
        if (state_n != state) begin
            cnt_n    = '0;
            glitch_n = '0;
        end
    end

    always_comb begin
        pll_rst_n = (state_n == PLL_RESET);
`ifdef PLL_LOCK_RST_SEQ_RETRY_LIMIT_EN
        if (state_n == FAIL)
            pll_rst_n = 1'b1;
`endif
    end

    // outputs are computed from state_n so they flip on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PLL_RESET;
            cnt      <= '0;
            glitch   <= '0;
            retry    <= 3'd0;
            loss_cnt <= 8'd0;
            pll_rst  <= 1'b1;
            rst_out  <= 1'b1;
            ready    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            glitch   <= glitch_n;
            retry    <= retry_n;
            loss_cnt <= loss_n;
            pll_rst  <= pll_rst_n;
            rst_out  <= (state_n != RUN);
            ready    <= (state_n == RUN);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq (RST=4, TIMEOUT=16, STABLE=8).
`timescale 1ns/1ps
module tb_pll_lock_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       rst_out;
    logic       ready;
    logic [7:0] loss_cnt;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;
    int bad      = 0;

    always #5 clk = ~clk;

    pll_lock_rst_seq #(
        .RST_CYCLES(4),
        .LOCK_TIMEOUT(16),
        .STABLE_CYCLES(8),
        .GLITCH_CYCLES(4),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .rst_out(rst_out),
        .ready(ready),
        .loss_cnt(loss_cnt),
        .state_dbg(state_dbg)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ready == rst_out) bad++;
        if (pll_rst && ready) bad++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic lose(output int pr, output int hi, output int n);
        pll_locked = 1'b0;
        repeat (4) step();
        pll_locked = 1'b1;
        pr = 0;
        hi = 0;
        n  = 0;
        do begin
            step();
            n++;
            if (pll_rst) pr++;
            if (rst_out) hi++;
        end while (!(ready && hi > 0) && n < 100);
    endtask

    int pr, hi, n, prev, nr, saw;
    int rise [4];

    initial begin
        // reset values
        do_reset();
        check("rst_state", state_dbg, 0);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_rst_out", rst_out, 1);
        check("rst_ready", ready, 0);
        check("rst_loss", loss_cnt, 0);

        // clean lock
        pr = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) pr++;
            step();
        end
        check("pll_rst_len", pr, 4);
        check("wait_state", state_dbg, 1);
        pll_locked = 1'b1;
        n = 0;
        while (rst_out && n < 100) begin
            step();
            n++;
        end
        check("lock_to_run", n, 11);
        check("run_ready", ready, 1);
        check("run_state", state_dbg, 3);
        check("run_pll_rst", pll_rst, 0);
        check("run_loss", loss_cnt, 0);

        // 3-cycle dropout is filtered
        hi = 0;
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rst_out) hi++;
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rst_out) hi++;
        end
        check("short_glitch_rst", hi, 0);
        check("short_glitch_loss", loss_cnt, 0);

        // 4-cycle dropout is a lock loss
        lose(pr, hi, n);
        check("loss_pll_rst_len", pr, 4);
        check("loss_rst_out_len", hi, 13);
        check("loss_relock_n", n, 15);
        check("loss_cnt1", loss_cnt, 1);
        check("loss_ready", ready, 1);
        lose(pr, hi, n);
        lose(pr, hi, n);
        check("loss_cnt3", loss_cnt, 3);

        // reset mid-operation
        rst = 1'b1;
        step();
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_pll_rst", pll_rst, 1);
        check("mid_rst_rst_out", rst_out, 1);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_loss", loss_cnt, 0);

        // timeout retry
        do_reset();
        prev = 1;
        nr   = 0;
        hi   = 0;
        saw  = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (pll_rst && prev == 0 && nr < 4) begin
                rise[nr] = c;
                nr++;
            end
            if (!rst_out) hi++;
            if (state_dbg == 3'd4) saw = 1;
            prev = int'(pll_rst);
        end
        check("to_nrise_ge3", (nr >= 3) ? 1 : 0, 1);
        check("to_first", rise[0], 20);
        check("to_gap1", rise[1] - rise[0], 20);
        check("to_gap2", rise[2] - rise[1], 20);
        check("to_rst_out", hi, 0);
`ifdef PLL_LOCK_RST_SEQ_RETRY_LIMIT_EN
        check("fail_seen", saw, 1);
        check("fail_state", state_dbg, 4);
        check("fail_pll_rst", pll_rst, 1);
        pll_locked = 1'b1;
        repeat (20) step();
        check("fail_hold", state_dbg, 4);
        check("fail_rst_out", rst_out, 1);
        check("fail_ready", ready, 0);
`else
        check("no_fail_state", saw, 0);
`endif

        // stability abort
        do_reset();
        repeat (6) step();
        pll_locked = 1'b1;
        n = 0;
        while (state_dbg != 3'd2 && n < 20) begin
            step();
            n++;
        end
        check("stab_enter", n, 3);
        repeat (4) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        n   = 0;
        saw = 0;
        while (rst_out && n < 100) begin
            step();
            n++;
            if (state_dbg == 3'd1) saw = 1;
        end
        check("stab_back_wait", saw, 1);
        check("stab_relock_n", n, 11);

        check("invariants", bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
